// File: rtl/control_regfile.sv
// AXI4-Lite control/status register file for the board evaluation engine.
// Define CONTROL_REGFILE_SLVERR_EN to return SLVERR on unmapped/RO accesses.
module control_regfile #(
   parameter int SIDE_WIDTH  = 32,
   parameter int BOARD_WORDS = 8,
   parameter int INDEX_WIDTH = 8,
   parameter int EVAL_WIDTH  = 24,
   parameter int ADDR_WIDTH  = 16
) (
   input  logic                                clk,
   input  logic                                aresetb,
   input  logic [ADDR_WIDTH-1:0]               axi_awaddr,
   input  logic                                axi_awvalid,
   output logic                                axi_awready,
   input  logic [31:0]                         axi_wdata,
   input  logic [3:0]                          axi_wstrb,
   input  logic                                axi_wvalid,
   output logic                                axi_wready,
   output logic [1:0]                          axi_bresp,
   output logic                                axi_bvalid,
   input  logic                                axi_bready,
   input  logic [ADDR_WIDTH-1:0]               axi_araddr,
   input  logic                                axi_arvalid,
   output logic                                axi_arready,
   output logic [31:0]                         axi_rdata,
   output logic [1:0]                          axi_rresp,
   output logic                                axi_rvalid,
   input  logic                                axi_rready,
   output logic                                soft_reset,
   output logic                                new_board_valid,
   output logic                                clear_moves,
   output logic                                clear_eval,
   output logic [BOARD_WORDS*SIDE_WIDTH-1:0]   new_board,
   output logic [INDEX_WIDTH-1:0]              move_index,
   output logic                                white_to_move,
   output logic [3:0]                          castle_mask,
   output logic [3:0]                          en_passant_col,
   input  logic                                moves_ready,
   input  logic                                move_ready,
   input  logic                                eval_valid,
   input  logic signed [EVAL_WIDTH-1:0]        eval,
   input  logic [BOARD_WORDS*SIDE_WIDTH-1:0]   initial_board
);

   localparam int WA = ADDR_WIDTH - 2;
   localparam int LW = (SIDE_WIDTH < 32) ? SIDE_WIDTH : 32;
   localparam int LI = (INDEX_WIDTH < 32) ? INDEX_WIDTH : 32;

   localparam logic [WA-1:0] A_CTRL = WA'(0);
   localparam logic [WA-1:0] A_MOVE = WA'(1);
   localparam logic [WA-1:0] A_POS  = WA'(2);
   localparam logic [WA-1:0] A_EVAL = WA'(3);
   localparam logic [WA-1:0] A_STAT = WA'(4);
   localparam logic [WA-1:0] A_NB   = WA'(16);
   localparam logic [WA-1:0] A_IB   = WA'(64);

   logic            run;
   logic            aw_lat;
   logic            w_lat;
   logic [WA-1:0]   aw_wa;
   logic [31:0]     w_data;
   logic [3:0]      w_strb;
   logic [31:0]     wmask;
   logic            do_write;
   logic [8:0]      pos;
   logic [WA-1:0]   ra;
   logic [31:0]     nb_rd;
   logic [31:0]     ib_rd;
   logic [31:0]     rd_word;
   logic [1:0]      wr_resp;
   logic [1:0]      rd_resp;
   logic            unused;

   function automatic logic in_board(logic [WA-1:0] a, logic [WA-1:0] base);
      return (a >= base) && (a < base + WA'(BOARD_WORDS));
   endfunction

   assign unused = ^{axi_awaddr[1:0], axi_araddr[1:0]};

   assign ra       = axi_araddr[ADDR_WIDTH-1:2];
   assign do_write = aw_lat && w_lat;
   assign wmask    = {{8{w_strb[3]}}, {8{w_strb[2]}},
                      {8{w_strb[1]}}, {8{w_strb[0]}}};

   assign {white_to_move, castle_mask, en_passant_col} = pos;

   // run keeps every ready low until the first clock after reset release
   assign axi_awready = run && !aw_lat && !axi_bvalid;
   assign axi_wready  = run && !w_lat && !axi_bvalid;
   assign axi_arready = run && !axi_rvalid;

`ifdef CONTROL_REGFILE_SLVERR_EN
   assign wr_resp = (aw_wa == A_CTRL || aw_wa == A_MOVE ||
                     aw_wa == A_POS || in_board(aw_wa, A_NB))
                    ? 2'b00 : 2'b10;
   assign rd_resp = (ra <= A_STAT || in_board(ra, A_NB) ||
                     in_board(ra, A_IB)) ? 2'b00 : 2'b10;
`else
   assign wr_resp = 2'b00;
   assign rd_resp = 2'b00;
`endif

   always_comb begin
      nb_rd = '0;
      ib_rd = '0;
      for (int i = 0; i < BOARD_WORDS; i++) begin
         if (ra == A_NB + WA'(i))
            nb_rd = 32'(new_board[i*SIDE_WIDTH +: LW]);
         if (ra == A_IB + WA'(i))
            ib_rd = 32'(initial_board[i*SIDE_WIDTH +: LW]);
      end
   end

   always_comb begin
      rd_word = '0;
      unique case (1'b1)
         ra == A_CTRL: rd_word = {soft_reset, 31'b0};
         ra == A_MOVE: rd_word = 32'(move_index);
         ra == A_POS:  rd_word = {23'b0, pos};
         ra == A_EVAL: rd_word = 32'(eval);
         ra == A_STAT: rd_word = {29'b0, eval_valid, move_ready, moves_ready};
         default:      rd_word = nb_rd | ib_rd;
      endcase
   end

   always_ff @(posedge clk or negedge aresetb) begin
      if (!aresetb) begin
         run             <= 1'b0;
         aw_lat          <= 1'b0;
         w_lat           <= 1'b0;
         aw_wa           <= '0;
         w_data          <= '0;
         w_strb          <= '0;
         axi_bvalid      <= 1'b0;
         axi_bresp       <= 2'b00;
         axi_rvalid      <= 1'b0;
         axi_rdata       <= '0;
         axi_rresp       <= 2'b00;
         soft_reset      <= 1'b0;
         new_board_valid <= 1'b0;
         clear_moves     <= 1'b0;
         clear_eval      <= 1'b0;
         new_board       <= '0;
         move_index      <= '0;
         pos             <= '0;
      end else begin
         run             <= 1'b1;
         new_board_valid <= 1'b0;
         clear_moves     <= 1'b0;
         clear_eval      <= 1'b0;
         if (axi_awvalid && axi_awready) begin
            aw_lat <= 1'b1;
            aw_wa  <= axi_awaddr[ADDR_WIDTH-1:2];
         end
         if (axi_wvalid && axi_wready) begin
            w_lat  <= 1'b1;
            w_data <= axi_wdata;
            w_strb <= axi_wstrb;
         end
         if (do_write) begin
            aw_lat     <= 1'b0;
            w_lat      <= 1'b0;
            axi_bvalid <= 1'b1;
            axi_bresp  <= wr_resp;
            if (aw_wa == A_CTRL) begin
               if (w_strb[0]) begin
                  new_board_valid <= w_data[0];
                  clear_moves     <= w_data[1];
                  clear_eval      <= w_data[2];
               end
               if (w_strb[3])
                  soft_reset <= w_data[31];
            end
            if (aw_wa == A_MOVE)
               move_index[LI-1:0] <= (move_index[LI-1:0] & ~wmask[LI-1:0]) |
                                     (w_data[LI-1:0] & wmask[LI-1:0]);
            if (aw_wa == A_POS)
               pos <= (pos & ~wmask[8:0]) | (w_data[8:0] & wmask[8:0]);
            for (int i = 0; i < BOARD_WORDS; i++) begin
               if (aw_wa == A_NB + WA'(i))
                  new_board[i*SIDE_WIDTH +: LW] <=
                     (new_board[i*SIDE_WIDTH +: LW] & ~wmask[LW-1:0]) |
                     (w_data[LW-1:0] & wmask[LW-1:0]);
            end
         end else if (axi_bvalid && axi_bready) begin
            axi_bvalid <= 1'b0;
         end
         // rdata samples pre-write state, so a colliding read sees the old value
         if (axi_arvalid && axi_arready) begin
            axi_rvalid <= 1'b1;
            axi_rdata  <= rd_word;
            axi_rresp  <= rd_resp;
         end else if (axi_rvalid && axi_rready) begin
            axi_rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_control_regfile.sv
// Directed self-checking bench for control_regfile.
module tb_control_regfile;

   logic         clk = 1'b0;
   logic         aresetb;
   logic [15:0]  axi_awaddr;
   logic         axi_awvalid;
   logic         axi_awready;
   logic [31:0]  axi_wdata;
   logic [3:0]   axi_wstrb;
   logic         axi_wvalid;
   logic         axi_wready;
   logic [1:0]   axi_bresp;
   logic         axi_bvalid;
   logic         axi_bready;
   logic [15:0]  axi_araddr;
   logic         axi_arvalid;
   logic         axi_arready;
   logic [31:0]  axi_rdata;
   logic [1:0]   axi_rresp;
   logic         axi_rvalid;
   logic         axi_rready;
   logic         soft_reset;
   logic         new_board_valid;
   logic         clear_moves;
   logic         clear_eval;
   logic [255:0] new_board;
   logic [7:0]   move_index;
   logic         white_to_move;
   logic [3:0]   castle_mask;
   logic [3:0]   en_passant_col;
   logic         moves_ready;
   logic         move_ready;
   logic         eval_valid;
   logic signed [23:0] eval;
   logic [255:0] initial_board;

   control_regfile dut (
      .clk(clk), .aresetb(aresetb),
      .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid),
      .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
      .axi_bready(axi_bready),
      .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
      .axi_arready(axi_arready),
      .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .soft_reset(soft_reset), .new_board_valid(new_board_valid),
      .clear_moves(clear_moves), .clear_eval(clear_eval),
      .new_board(new_board), .move_index(move_index),
      .white_to_move(white_to_move), .castle_mask(castle_mask),
      .en_passant_col(en_passant_col),
      .moves_ready(moves_ready), .move_ready(move_ready),
      .eval_valid(eval_valid), .eval(eval),
      .initial_board(initial_board)
   );

   always #5 clk = ~clk;

`ifdef CONTROL_REGFILE_SLVERR_EN
   localparam logic [1:0] ERR = 2'b10;
`else
   localparam logic [1:0] ERR = 2'b00;
`endif
   localparam logic [1:0] OK = 2'b00;

   typedef struct {
      logic [15:0] wa;
      logic [31:0] wd;
      logic [3:0]  ws;
      logic [15:0] ra;
      logic [31:0] rexp;
      logic [1:0]  bexp;
      logic [1:0]  rrexp;
   } vec_t;

   vec_t vecs [15];

   int checks = 0;
   int errors = 0;
   int n_nbv = 0;
   int n_clm = 0;
   int n_cle = 0;
   int n_bv = 0;

   always @(negedge clk) begin
      if (new_board_valid) n_nbv++;
      if (clear_moves) n_clm++;
      if (clear_eval) n_cle++;
      if (axi_bvalid) n_bv++;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s timeout", nm);
   endtask

   task automatic axi_write(input logic [15:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
      int n;
      bit hs_aw;
      bit hs_w;
      resp = 2'bxx;
      @(negedge clk);
      axi_awaddr = a; axi_awvalid = 1'b1;
      axi_wdata = d; axi_wstrb = s; axi_wvalid = 1'b1;
      axi_bready = 1'b1;
      n = 0;
      while ((axi_awvalid || axi_wvalid) && n < 20) begin
         hs_aw = axi_awvalid && axi_awready;
         hs_w = axi_wvalid && axi_wready;
         @(posedge clk); #1;
         if (hs_aw) axi_awvalid = 1'b0;
         if (hs_w) axi_wvalid = 1'b0;
         @(negedge clk);
         n++;
      end
      if (axi_awvalid || axi_wvalid) begin
         axi_awvalid = 1'b0; axi_wvalid = 1'b0;
         timeout("write_accept");
         return;
      end
      n = 0;
      while (!axi_bvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!axi_bvalid) begin
         timeout("write_bvalid");
         return;
      end
      resp = axi_bresp;
      @(posedge clk); #1;
      axi_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [15:0] a, output logic [31:0] d,
                           output logic [1:0] resp);
      int n;
      d = 'x; resp = 2'bxx;
      @(negedge clk);
      axi_araddr = a; axi_arvalid = 1'b1; axi_rready = 1'b1;
      n = 0;
      while (!axi_arready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!axi_arready) begin
         axi_arvalid = 1'b0;
         timeout("read_accept");
         return;
      end
      @(posedge clk); #1;
      axi_arvalid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!axi_rvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!axi_rvalid) begin
         timeout("read_rvalid");
         return;
      end
      d = axi_rdata;
      resp = axi_rresp;
      @(posedge clk); #1;
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_awready"}, 32'(axi_awready), 32'd0);
      chk({tag, "_wready"}, 32'(axi_wready), 32'd0);
      chk({tag, "_arready"}, 32'(axi_arready), 32'd0);
      chk({tag, "_bvalid"}, 32'(axi_bvalid), 32'd0);
      chk({tag, "_rvalid"}, 32'(axi_rvalid), 32'd0);
      chk({tag, "_rdata"}, axi_rdata, 32'd0);
      chk({tag, "_soft_reset"}, 32'(soft_reset), 32'd0);
      chk({tag, "_move_index"}, 32'(move_index), 32'd0);
      chk({tag, "_pos"},
          32'({white_to_move, castle_mask, en_passant_col}), 32'd0);
      chk({tag, "_pulses"},
          32'({new_board_valid, clear_moves, clear_eval}), 32'd0);
      chk({tag, "_new_board"}, 32'(|new_board), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [1:0]  r;
      logic [1:0]  rr;
      logic [31:0] d;
      int b_nbv, b_clm, b_cle, b_bv, n;

      vecs[0]  = '{16'h0004, 32'h00000012, 4'hF, 16'h0004, 32'h00000012, OK, OK};
      vecs[1]  = '{16'h0004, 32'hFFFFFFFF, 4'h1, 16'h0004, 32'h000000FF, OK, OK};
      vecs[2]  = '{16'h0004, 32'h00000000, 4'hE, 16'h0004, 32'h000000FF, OK, OK};
      vecs[3]  = '{16'h0008, 32'h000001A5, 4'hF, 16'h0008, 32'h000001A5, OK, OK};
      vecs[4]  = '{16'h0008, 32'h00000000, 4'h1, 16'h0008, 32'h00000100, OK, OK};
      vecs[5]  = '{16'h0044, 32'hDEADBEEF, 4'hF, 16'h0044, 32'hDEADBEEF, OK, OK};
      vecs[6]  = '{16'h0044, 32'h00000000, 4'h4, 16'h0044, 32'hDE00BEEF, OK, OK};
      vecs[7]  = '{16'h005C, 32'hCAFEF00D, 4'hF, 16'h005C, 32'hCAFEF00D, OK, OK};
      vecs[8]  = '{16'h0060, 32'h00000055, 4'hF, 16'h0060, 32'h00000000, ERR, ERR};
      vecs[9]  = '{16'h000C, 32'h00000000, 4'hF, 16'h000C, 32'hFFFFFFFD, ERR, OK};
      vecs[10] = '{16'h0010, 32'hFFFFFFFF, 4'hF, 16'h0010, 32'h00000005, ERR, OK};
      vecs[11] = '{16'h0100, 32'h00000000, 4'hF, 16'h0100, 32'hA0000000, ERR, OK};
      vecs[12] = '{16'h011C, 32'h00000000, 4'hF, 16'h011C, 32'hA0000007, ERR, OK};
      vecs[13] = '{16'h0120, 32'h00000001, 4'hF, 16'h0120, 32'h00000000, ERR, ERR};
      vecs[14] = '{16'h0014, 32'h00000001, 4'hF, 16'h0014, 32'h00000000, ERR, ERR};

      aresetb = 1'b0;
      axi_awaddr = '0; axi_awvalid = 1'b0;
      axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 1'b0;
      axi_bready = 1'b0;
      axi_araddr = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
      moves_ready = 1'b1; move_ready = 1'b0; eval_valid = 1'b1;
      eval = -24'sd3;
      for (int i = 0; i < 8; i++)
         initial_board[i*32 +: 32] = 32'hA0000000 | 32'(i);

      repeat (3) @(negedge clk);
      chk_idle_zero("rst");
      aresetb = 1'b1;
      #1 chk("rel_awready_pre", 32'(axi_awready), 32'd0);
      @(posedge clk); #1;
      chk("rel_awready", 32'(axi_awready), 32'd1);
      chk("rel_wready", 32'(axi_wready), 32'd1);
      chk("rel_arready", 32'(axi_arready), 32'd1);

      // AW two cycles ahead of W
      @(negedge clk);
      axi_awaddr = 16'h0040; axi_awvalid = 1'b1; axi_bready = 1'b0;
      chk("aw_first_ready", 32'(axi_awready), 32'd1);
      @(posedge clk); #1 axi_awvalid = 1'b0;
      @(negedge clk);
      chk("aw_latched_ready", 32'(axi_awready), 32'd0);
      chk("w_wait_ready", 32'(axi_wready), 32'd1);
      @(posedge clk); #1;
      axi_wdata = 32'h00001234; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
      @(negedge clk);
      chk("bvalid_before_w", 32'(axi_bvalid), 32'd0);
      @(posedge clk); #1 axi_wvalid = 1'b0;
      @(negedge clk);
      chk("bvalid_w_latched", 32'(axi_bvalid), 32'd0);
      @(negedge clk);
      chk("bvalid_rise", 32'(axi_bvalid), 32'd1);
      chk("bresp_board", 32'(axi_bresp), 32'd0);
      chk("awready_in_b", 32'(axi_awready), 32'd0);
      chk("wready_in_b", 32'(axi_wready), 32'd0);
      @(negedge clk);
      chk("bvalid_hold", 32'(axi_bvalid), 32'd1);
      axi_bready = 1'b1;
      @(posedge clk); #1 axi_bready = 1'b0;
      @(negedge clk);
      chk("bvalid_drop", 32'(axi_bvalid), 32'd0);
      chk("awready_back", 32'(axi_awready), 32'd1);
      axi_read(16'h0040, d, rr);
      chk("board0_read", d, 32'h00001234);
      chk("board0_out", new_board[31:0], 32'h00001234);

      for (int i = 0; i < 15; i++) begin
         axi_write(vecs[i].wa, vecs[i].wd, vecs[i].ws, r);
         chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].bexp));
         axi_read(vecs[i].ra, d, rr);
         chk($sformatf("vec%0d_rdata", i), d, vecs[i].rexp);
         chk($sformatf("vec%0d_rresp", i), 32'(rr), 32'(vecs[i].rrexp));
      end
      chk("out_move_index", 32'(move_index), 32'h000000FF);
      chk("out_white", 32'(white_to_move), 32'd1);
      chk("out_castle", 32'(castle_mask), 32'd0);
      chk("out_ep", 32'(en_passant_col), 32'd0);
      chk("out_board1", new_board[63:32], 32'hDE00BEEF);
      chk("out_board7", new_board[255:224], 32'hCAFEF00D);

      // control pulses and soft_reset lane gating
      b_nbv = n_nbv; b_clm = n_clm; b_cle = n_cle;
      axi_write(16'h0000, 32'h80000007, 4'hF, r);
      chk("ctrl_bresp", 32'(r), 32'd0);
      repeat (3) @(negedge clk);
      chk("nbv_width", 32'(n_nbv - b_nbv), 32'd1);
      chk("clm_width", 32'(n_clm - b_clm), 32'd1);
      chk("cle_width", 32'(n_cle - b_cle), 32'd1);
      chk("soft_reset_set", 32'(soft_reset), 32'd1);
      axi_write(16'h0000, 32'h00000007, 4'b0110, r);
      axi_write(16'h0000, 32'h00000000, 4'b0111, r);
      repeat (2) @(negedge clk);
      chk("nbv_lane0_off", 32'(n_nbv - b_nbv), 32'd1);
      chk("soft_reset_lane3_off", 32'(soft_reset), 32'd1);
      axi_read(16'h0000, d, rr);
      chk("ctrl_read", d, 32'h80000000);
      axi_write(16'h0000, 32'h00000000, 4'b1000, r);
      @(negedge clk);
      chk("soft_reset_clear", 32'(soft_reset), 32'd0);

      // read data held under rready backpressure
      @(negedge clk);
      axi_araddr = 16'h000C; axi_arvalid = 1'b1; axi_rready = 1'b0;
      n = 0;
      while (!axi_arready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      axi_arvalid = 1'b0;
      eval = 24'sd5;
      @(negedge clk);
      chk("bp_rvalid", 32'(axi_rvalid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp%0d_rdata", k), axi_rdata, 32'hFFFFFFFD);
         chk($sformatf("bp%0d_arready", k), 32'(axi_arready), 32'd0);
         @(negedge clk);
      end
      axi_rready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_rvalid_drop", 32'(axi_rvalid), 32'd0);
      eval = -24'sd3;

      // read colliding with write commit returns old value
      @(negedge clk);
      axi_awaddr = 16'h0004; axi_awvalid = 1'b1;
      axi_wdata = 32'h00000077; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
      axi_bready = 1'b0;
      @(posedge clk); #1;
      axi_awvalid = 1'b0; axi_wvalid = 1'b0;
      axi_araddr = 16'h0004; axi_arvalid = 1'b1; axi_rready = 1'b1;
      @(negedge clk);
      chk("col_arready", 32'(axi_arready), 32'd1);
      @(posedge clk); #1 axi_arvalid = 1'b0;
      @(negedge clk);
      chk("col_rvalid", 32'(axi_rvalid), 32'd1);
      chk("col_rdata_old", axi_rdata, 32'h000000FF);
      chk("col_bvalid", 32'(axi_bvalid), 32'd1);
      chk("col_move_new", 32'(move_index), 32'h00000077);
      axi_bready = 1'b1;
      @(posedge clk); #1 axi_bready = 1'b0;
      axi_read(16'h0004, d, rr);
      chk("col_reread", d, 32'h00000077);

      // reset with AW latched and W pending
      b_bv = n_bv;
      @(negedge clk);
      axi_awaddr = 16'h0004; axi_awvalid = 1'b1; axi_wvalid = 1'b0;
      @(posedge clk); #1 axi_awvalid = 1'b0;
      @(negedge clk);
      chk("mid_aw_latched", 32'(axi_awready), 32'd0);
      chk("mid_w_open", 32'(axi_wready), 32'd1);
      #1 aresetb = 1'b0;
      #1 chk_idle_zero("mid_rst");
      repeat (2) @(negedge clk);
      aresetb = 1'b1;
      #1 chk("mid_awready_pre", 32'(axi_awready), 32'd0);
      @(posedge clk); #1;
      chk("mid_awready", 32'(axi_awready), 32'd1);
      chk("mid_wready", 32'(axi_wready), 32'd1);
      chk("mid_arready", 32'(axi_arready), 32'd1);
      repeat (3) @(negedge clk);
      chk("mid_no_bvalid", 32'(n_bv - b_bv), 32'd0);
      axi_write(16'h0004, 32'h0000005A, 4'hF, r);
      chk("post_rst_bresp", 32'(r), 32'd0);
      axi_read(16'h0004, d, rr);
      chk("post_rst_read", d, 32'h0000005A);
      chk("post_rst_move", 32'(move_index), 32'h0000005A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_regfile.md
CONTROL_REGFILE -- requirements
Module: control_regfile

Interface
REQ-001 SHALL have parameter SIDE_WIDTH, default 32, width in bits of one board word.
REQ-002 SHALL have parameter BOARD_WORDS, default 8, number of board words (1..32).
REQ-003 SHALL have parameter INDEX_WIDTH, default 8, width of move_index.
REQ-004 SHALL have parameter EVAL_WIDTH, default 24, width of signed eval.
REQ-005 SHALL have parameter ADDR_WIDTH, default 16, AXI byte-address width.
REQ-006 SHALL have ports:
  clk  in  1  sole clock
  aresetb  in  1  asynchronous active-low reset
  axi_awaddr/axi_awvalid/axi_awready  in/in/out  ADDR_WIDTH/1/1  write address channel
  axi_wdata/axi_wstrb/axi_wvalid/axi_wready  in/in/in/out  32/4/1/1  write data channel
  axi_bresp/axi_bvalid/axi_bready  out/out/in  2/1/1  write response channel
  axi_araddr/axi_arvalid/axi_arready  in/in/out  ADDR_WIDTH/1/1  read address channel
  axi_rdata/axi_rresp/axi_rvalid/axi_rready  out/out/out/in  32/2/1/1  read data channel
  soft_reset  out  1  level, software-controlled
  new_board_valid, clear_moves, clear_eval  out  1 each  single-cycle pulses
  new_board  out  BOARD_WORDS*SIDE_WIDTH  board image
  move_index  out  INDEX_WIDTH  selected move
  white_to_move, castle_mask, en_passant_col  out  1/4/4  position state
  moves_ready, move_ready, eval_valid  in  1 each  status
  eval  in  EVAL_WIDTH  signed evaluation
  initial_board  in  BOARD_WORDS*SIDE_WIDTH  board readback
  The axi_awprot/axi_arprot inputs SHALL be absent.

Function
REQ-007 Word address SHALL be addr[ADDR_WIDTH-1:2]; map: 0x00 CTRL, 0x01 move_index, 0x02 {white_to_move,castle_mask,en_passant_col} in bits 8:0, 0x03 eval sign-extended to 32 (RO), 0x04 status {eval_valid,move_ready,moves_ready} in bits 2:0 (RO), 0x10+i new_board word i (RW), 0x40+i initial_board word i (RO), i<BOARD_WORDS.
REQ-008 CTRL write: bit0 pulses new_board_valid, bit1 pulses clear_moves, bit2 pulses clear_eval, bit31 sets soft_reset level; CTRL read: bit31 = soft_reset, bits 2:0 read 0.
REQ-009 Pulses SHALL be exactly one clk wide, asserted the cycle after write commit.
REQ-010 awready and wready SHALL be independent: each is high when its channel has no latched beat and bvalid is low; AW and W accepted in any order or the same cycle.
REQ-011 Write SHALL commit the cycle after both AW and W are latched; bvalid rises in the commit cycle and holds until bready; no new AW/W accepted while bvalid is high.
REQ-012 wstrb byte lanes SHALL be honoured on RW registers; pulse bits act only when lane 0 is enabled; soft_reset only when lane 3 is enabled.
REQ-013 Writes to RO or unmapped addresses SHALL change no state.
REQ-014 arready SHALL be high whenever rvalid is low; on arvalid&&arready, rdata is registered and rvalid rises the next cycle, held stable until rready.
REQ-015 A read and write to the same register committing in the same cycle SHALL return the pre-write value.
REQ-016 Unused upper rdata bits and unmapped reads SHALL return 0; SIDE_WIDTH>32 truncates, <32 zero-extends.

Reset
REQ-017 aresetb low SHALL asynchronously clear all outputs, internal latches and registers to 0, including the ready signals, bvalid, rvalid and soft_reset.
REQ-018 Reset mid-transaction SHALL discard latched AW/W and pending responses; awready, wready and arready rise on the first clk after release.

Configuration
REQ-019 With CONTROL_REGFILE_SLVERR_EN defined, bresp/rresp SHALL be 2'b10 for unmapped addresses and for writes to RO registers; without it, all responses SHALL be 2'b00.

Verification
REQ-020 Write 0x1234 to 0x40 (word 0x10), AW two cycles before W -> bvalid one cycle after W accepted, bresp 0; read of 0x40 returns 0x00001234.
REQ-021 Write 0x80000007 to CTRL -> new_board_valid, clear_moves and clear_eval each high exactly one cycle; soft_reset stays 1; CTRL read returns 0x80000000.
REQ-022 Hold rready low 5 cycles after a read of 0x0C with eval=-3 -> rdata stays 0xFFFFFFFD, arready low throughout.
REQ-023 Write to 0x0C with the macro defined -> bresp 2'b10, eval readback unchanged; without the macro -> bresp 2'b00.
REQ-024 Write wstrb=4'b0001 data 0xFFFFFFFF to 0x04 -> move_index low byte 0xFF, other bits unchanged.
REQ-025 Assert aresetb low while AW is latched and W pending -> bvalid never rises, all outputs 0; after release, a fresh write completes normally.
